// File: rtl/cpu_controller_pkg.sv
// Shared types and constants for the accumulator CPU sequencing controller.
package cpu_controller_pkg;

  localparam int unsigned OPCODE_WIDTH = 3;
  localparam int unsigned PHASE_WIDTH  = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [PHASE_WIDTH-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
    logic halt;
  } strobes_t;

  // Unknown opcodes fall to default, so an X opcode never counts as an ALU op.
  function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
    logic r;
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_LDA: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// Wrapping instruction-cycle phase counter with synchronous reset and hold.
module cpu_phase_counter
  import cpu_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_hold,
  output logic [PHASE_WIDTH-1:0] o_phase
);

  logic [PHASE_WIDTH-1:0] r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (!i_hold) begin
      r_phase <= r_phase + PHASE_WIDTH'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/cpu_controller.sv
// Sequencing control unit: per-phase strobe decode plus the sticky HALTED state.
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    inc_pc,
  output logic                    ld_pc,
  output logic                    ld_ac,
  output logic                    wr,
  output logic                    data_e,
  output logic                    halt,
  output logic [PHASE_WIDTH-1:0]  phase
);

  ctrl_state_e            r_state;
  ctrl_state_e            w_state_next;
  logic [PHASE_WIDTH-1:0] w_phase;
  logic                   w_hold;
  logic                   w_aluop;
  strobes_t               w_strb;

  cpu_phase_counter u_phase_counter (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (w_hold),
    .o_phase (w_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and Mealy strobe decode; rst forces every strobe low.
  always_comb begin
    w_state_next = r_state;
    w_hold       = 1'b0;
    w_strb       = '0;
    w_aluop      = is_aluop(opcode);

    case (r_state)
      ST_RUN: begin
        case (w_phase)
          PH_INST_ADDR: begin
            w_strb.sel = 1'b1;
          end
          PH_INST_FETCH: begin
            w_strb.sel = 1'b1;
            w_strb.rd  = 1'b1;
          end
          PH_INST_LOAD, PH_IDLE: begin
            w_strb.sel   = 1'b1;
            w_strb.rd    = 1'b1;
            w_strb.ld_ir = 1'b1;
          end
          PH_OP_ADDR: begin
            // Halting freezes the phase at 4 on the same edge HALTED is entered.
            if (opcode == OP_HLT) begin
              w_strb.halt  = 1'b1;
              w_hold       = 1'b1;
              w_state_next = ST_HALTED;
            end else begin
              w_strb.inc_pc = 1'b1;
            end
          end
          PH_OP_FETCH, PH_ALU_OP, PH_STORE: begin
            w_strb.rd    = w_aluop;
            w_strb.ld_ac = w_aluop && (w_phase == PH_STORE);
            case (opcode)
              OP_SKZ: w_strb.inc_pc = zero && (w_phase == PH_ALU_OP);
              OP_JMP: begin
                w_strb.ld_pc  = (w_phase != PH_OP_FETCH);
                w_strb.inc_pc = (w_phase == PH_STORE);
              end
              OP_STO: begin
                w_strb.data_e = (w_phase != PH_OP_FETCH);
                w_strb.wr     = (w_phase == PH_STORE);
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      ST_HALTED: begin
        w_strb.halt = 1'b1;
        w_hold      = 1'b1;
      end
      default: w_state_next = ST_RUN;
    endcase

    if (rst) begin
      w_strb = '0;
    end
  end

  assign sel    = w_strb.sel;
  assign rd     = w_strb.rd;
  assign ld_ir  = w_strb.ld_ir;
  assign inc_pc = w_strb.inc_pc;
  assign ld_pc  = w_strb.ld_pc;
  assign ld_ac  = w_strb.ld_ac;
  assign wr     = w_strb.wr;
  assign data_e = w_strb.data_e;
  assign halt   = w_strb.halt;
  assign phase  = w_phase;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: directed plan sequences then random stimulus.
module tb_cpu_controller;

  localparam int HLT = 0, SKZ = 1, ADD = 2, AND_ = 3, XOR_ = 4, LDA = 5, STO = 6, JMP = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [8:0] strb;  // {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_phase = 0;
  bit   m_halted = 1'b0;
  bit   drv_done = 1'b0;
  int   cyc = 0;

  // Reference strobes as boolean rules over phase number and opcode.
  function automatic logic [8:0] model(input int ph, input bit halted, input bit r,
                                       input int op, input bit z);
    bit alu, s_sel, s_rd, s_ldir, s_inc, s_ldpc, s_ldac, s_wr, s_de, s_halt;
    if (r) return 9'd0;
    if (halted) return 9'b0_0000_0001;
    alu    = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    s_sel  = (ph <= 3);
    s_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    s_ldir = (ph == 2) || (ph == 3);
    s_inc  = (ph == 4 && op != HLT) || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP);
    s_ldpc = (op == JMP) && (ph == 6 || ph == 7);
    s_ldac = alu && ph == 7;
    s_wr   = (op == STO) && ph == 7;
    s_de   = (op == STO) && (ph == 6 || ph == 7);
    s_halt = (ph == 4) && (op == HLT);
    return {s_sel, s_rd, s_ldir, s_inc, s_ldpc, s_ldac, s_wr, s_de, s_halt};
  endfunction

  task automatic step(input bit r, input int op, input bit z);
    exp_t e;
    @(negedge clk);
    rst    = r;
    opcode = 3'(op);
    zero   = z;
    cyc++;
    e.ph   = 3'(m_phase);
    e.strb = model(m_phase, m_halted, r, op, z);
    e.cyc  = cyc;
    exp_q.push_back(e);
    if (r) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      m_phase = m_phase;
    end else if (m_phase == 4 && op == HLT) begin
      m_halted = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic run(input int n, input int op, input bit z);
    for (int i = 0; i < n; i++) step(1'b0, op, z);
  endtask

  task automatic run_to(input int ph, input int op);
    for (int i = 0; i < 16 && m_phase != ph; i++) step(1'b0, op, 1'b0);
  endtask

  // Driver
  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    step(1'b1, ADD, 1'b0);
    run(9, ADD, 1'b0);
    run_to(0, ADD);
    run(8, STO, 1'b0);
    run(8, SKZ, 1'b1);
    run(8, SKZ, 1'b0);
    run(8, JMP, 1'b0);
    run_to(4, ADD);
    run(12, HLT, 1'b0);
    step(1'b1, ADD, 1'b0);
    run(3, ADD, 1'b0);
    run_to(6, LDA);
    step(1'b1, LDA, 1'b0);
    run(10, LDA, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      bit r;
      int op;
      r  = ($urandom_range(0, 39) == 0);
      op = ($urandom_range(0, 29) == 0) ? HLT : int'($urandom_range(1, 7));
      step(r, op, 1'($urandom_range(0, 1)));
    end
    drv_done = 1'b1;
  end

  // Monitor: outputs are sampled mid-low-phase, well away from the rising edge.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
        n_tests++;
        if (phase !== e.ph) begin
          n_fail++;
          $display("FAIL phase cyc=%0d actual=%0d required=%0d", e.cyc, phase, e.ph);
        end
        n_tests++;
        if (act !== e.strb) begin
          n_fail++;
          $display("FAIL strobes cyc=%0d phase=%0d actual=%b required=%b (sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt)",
                   e.cyc, e.ph, act, e.strb);
        end
      end else if (drv_done) begin
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=unfinished required=finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
